// File: rtl/pipe_control_unit.sv
// pipe_control_unit
//   Control path for a 5-stage pipeline. Decodes the ID-stage opcode,
//   carries the control bundle through the ID/EX, EX/MEM and MEM/WB control
//   registers, detects load-use hazards, resolves branches in MEM and
//   drives the PC / IF-ID stall and flush controls. Keeps saturating
//   stall and flush event counters.
//
// Ports
//   clk, reset              clock, async active-high reset
//   id_opcode, id_rs, id_rt instruction fields held in IF/ID
//   ex_rt                   rt field held in the datapath ID/EX register
//   mem_zero                ALU zero flag held in EX/MEM
//   pc_write, if_id_write   write enables (0 while stalling)
//   if_id_flush             IF/ID clears to a nop on the next edge
//   pc_src                  select branch target from MEM
//   id_jump                 select jump target (combinational decode)
//   ex_* / mem_* / wb_*     registered stage controls
//   illegal_op              one-cycle pulse for an undecoded opcode
//   stall_cnt, flush_cnt    saturating event counters
module pipe_control_unit #(
  parameter int REG_AW  = 5,
  parameter int EXT_OPS = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              mem_zero,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              pc_src,
  output logic              id_jump,
  output logic              ex_RegDst,
  output logic              ex_aluSrc,
  output logic [1:0]        ex_aluOp,
  output logic              ex_memRead,
  output logic              mem_memRead,
  output logic              mem_memWrite,
  output logic              wb_MemtoReg,
  output logic              wb_regWrite,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // ID decode
  logic       d_regdst, d_alusrc, d_branch, d_bne;
  logic       d_memread, d_memwrite, d_memtoreg, d_regwrite;
  logic       d_jump, d_illegal;
  logic [1:0] d_aluop;

  // stage registers not visible on the ports
  logic ex_branch, ex_bne, ex_memWrite, ex_MemtoReg, ex_regWrite;
  logic mem_branch, mem_bne, mem_MemtoReg, mem_regWrite;

  logic hz;
  logic stall_evt, flush_evt;

  always_comb begin
    d_regdst   = 1'b0;
    d_alusrc   = 1'b0;
    d_aluop    = 2'b00;
    d_branch   = 1'b0;
    d_bne      = 1'b0;
    d_memread  = 1'b0;
    d_memwrite = 1'b0;
    d_memtoreg = 1'b0;
    d_regwrite = 1'b0;
    d_jump     = 1'b0;
    d_illegal  = 1'b0;
    case (id_opcode)
      OP_RTYPE: begin
        d_regdst   = 1'b1;
        d_aluop    = 2'b10;
        d_regwrite = 1'b1;
      end
      OP_LW: begin
        d_alusrc   = 1'b1;
        d_memread  = 1'b1;
        d_memtoreg = 1'b1;
        d_regwrite = 1'b1;
      end
      OP_SW: begin
        d_alusrc   = 1'b1;
        d_memwrite = 1'b1;
      end
      OP_BEQ: begin
        d_aluop  = 2'b01;
        d_branch = 1'b1;
      end
      OP_J: d_jump = 1'b1;
      OP_ADDI: begin
        if (EXT_OPS != 0) begin
          d_alusrc   = 1'b1;
          d_regwrite = 1'b1;
        end else begin
          d_illegal = 1'b1;
        end
      end
      OP_BNE: begin
        if (EXT_OPS != 0) begin
          d_aluop  = 2'b01;
          d_branch = 1'b1;
          d_bne    = 1'b1;
        end else begin
          d_illegal = 1'b1;
        end
      end
      default: d_illegal = 1'b1;
    endcase
  end

  // Register 0 is never a real dependency, so a load targeting it cannot stall.
  assign hz = ex_memRead && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

  assign pc_src  = mem_branch && (mem_zero ^ mem_bne);
  assign id_jump = d_jump;

  // A taken branch overrides the stall: the stalled instruction is squashed anyway.
  assign stall_evt   = hz && !pc_src;
  assign flush_evt   = pc_src || (!hz && d_jump);
  assign pc_write    = !stall_evt;
  assign if_id_write = !stall_evt;
  assign if_id_flush = flush_evt;

  // ID/EX: bubble on stall or branch squash
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_RegDst   <= 1'b0;
      ex_aluSrc   <= 1'b0;
      ex_aluOp    <= 2'b00;
      ex_branch   <= 1'b0;
      ex_bne      <= 1'b0;
      ex_memRead  <= 1'b0;
      ex_memWrite <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_regWrite <= 1'b0;
    end else if (pc_src || hz) begin
      ex_RegDst   <= 1'b0;
      ex_aluSrc   <= 1'b0;
      ex_aluOp    <= 2'b00;
      ex_branch   <= 1'b0;
      ex_bne      <= 1'b0;
      ex_memRead  <= 1'b0;
      ex_memWrite <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_regWrite <= 1'b0;
    end else begin
      ex_RegDst   <= d_regdst;
      ex_aluSrc   <= d_alusrc;
      ex_aluOp    <= d_aluop;
      ex_branch   <= d_branch;
      ex_bne      <= d_bne;
      ex_memRead  <= d_memread;
      ex_memWrite <= d_memwrite;
      ex_MemtoReg <= d_memtoreg;
      ex_regWrite <= d_regwrite;
    end
  end

  // EX/MEM: squashed by a taken branch, otherwise advances (also during a stall)
  always_ff @(posedge clk or posedge reset) begin
    if (reset || pc_src) begin
      mem_branch   <= 1'b0;
      mem_bne      <= 1'b0;
      mem_memRead  <= 1'b0;
      mem_memWrite <= 1'b0;
      mem_MemtoReg <= 1'b0;
      mem_regWrite <= 1'b0;
    end else begin
      mem_branch   <= ex_branch;
      mem_bne      <= ex_bne;
      mem_memRead  <= ex_memRead;
      mem_memWrite <= ex_memWrite;
      mem_MemtoReg <= ex_MemtoReg;
      mem_regWrite <= ex_regWrite;
    end
  end

  // MEM/WB always advances so a taken branch still retires
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_MemtoReg <= 1'b0;
      wb_regWrite <= 1'b0;
    end else begin
      wb_MemtoReg <= mem_MemtoReg;
      wb_regWrite <= mem_regWrite;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_op <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      illegal_op <= d_illegal && !hz && !pc_src;
      if (stall_evt && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_evt && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule
